// File: rtl/uart_tx_device.sv
// Register-mapped 8N1 UART transmitter with a small transmit FIFO.
// Offset 0 pushes bytes, offset 1 reports full/empty/busy/overflow.
module uart_tx_device #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_wen,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       tx
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = 16;
    localparam int unsigned IDX_W  = 3;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_BIT   = IDX_W'(7);
    localparam logic [7:0]        ADDR_DATA  = 8'h00;
    localparam logic [7:0]        ADDR_STATE = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [BAUD_W-1:0]  baud;
    logic [BAUD_W-1:0]  baud_n;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_idx_n;
    logic [7:0]         shreg;
    logic               tx_n;
    logic               pop;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               overflow;

    logic               wr_data;
    logic               wr_state;
    logic               rd_state;
    logic               push;
    logic               baud_done;
    logic [7:0]         status;

    // Register decode; fullness is taken before any same-cycle pop.
    assign wr_data    = req_valid && req_wen && (req_addr == ADDR_DATA);
    assign wr_state   = req_valid && req_wen && (req_addr == ADDR_STATE);
    assign rd_state   = req_valid && !req_wen && (req_addr == ADDR_STATE);
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign push       = wr_data && !fifo_full;
    assign baud_done  = (baud == BAUD_LAST);
    assign status     = {4'b0000, overflow, (state != IDLE), fifo_empty, fifo_full};

    // Next-state, baud/bit sequencing and FIFO pop request.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n    = '0;
                    bit_idx_n = bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP;
                    end
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            default: begin
                baud_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Line level follows the current state, one register stage behind it.
    always_comb begin
        tx_n = 1'b1;
        case (state)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg[bit_idx];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
            if (pop) begin
                shreg <= mem[rd_ptr];
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_data && fifo_full) begin
            overflow <= 1'b1;
        end else if (wr_state && req_wdata[3]) begin
            overflow <= 1'b0;
        end
    end

    // Every request gets a response next cycle; only STATE reads carry data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= req_valid;
            resp_rdata <= rd_state ? status : 8'h00;
        end
    end

endmodule
